csr_exec_queue: RTL

//  Multi-lane in-order CSR execution queue between dispatch and the CSR file.

---
 rtl/csr_exec_pkg.sv | 38 +++
 rtl/csr_newval_calc.sv | 51 +++++
 rtl/csr_exec_queue.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/csr_exec_pkg.sv
// Shared types for the CSR execution queue: op encoding, entry state and the
// per-entry record held in the queue.
package csr_exec_pkg;

  localparam int XLEN  = 64;
  localparam int TAG_W = 6;
  localparam int RD_W  = 7;

  // CSR addresses whose top two bits are set are read-only
  localparam logic [1:0] RO_CSR_PREFIX = 2'b11;

  // bit 2 selects the immediate form, bits 1:0 select write/set/clear
  typedef enum logic [2:0] {
    CSR_RW  = 3'b001,
    CSR_RS  = 3'b010,
    CSR_RC  = 3'b011,
    CSR_RWI = 3'b101,
    CSR_RSI = 3'b110,
    CSR_RCI = 3'b111
  } csr_op_e;

  typedef logic [1:0] csrq_state_e;
  localparam csrq_state_e ST_FREE = 2'd0;
  localparam csrq_state_e ST_WAIT = 2'd1;
  localparam csrq_state_e ST_DONE = 2'd2;

  typedef struct packed {
    csrq_state_e       state;
    csr_op_e           op;
    logic [11:0]       csr;
    logic [XLEN-1:0]   src;
    logic [4:0]        uimm;
    logic              rs1_zero;
    logic [TAG_W-1:0]  tag;
    logic [RD_W-1:0]   rd;
  } csrq_entry_t;

endpackage

// File: rtl/csr_newval_calc.sv
// Combinational CSR update: derives the value to write back, whether the op
// writes at all, and whether that write targets a read-only CSR.
module csr_newval_calc
  import csr_exec_pkg::*;
(
  input  csr_op_e          op,
  input  logic [1:0]       csr_prefix,
  input  logic [XLEN-1:0]  old_val,
  input  logic [XLEN-1:0]  src,
  input  logic [4:0]       uimm,
  input  logic             rs1_zero,
  output logic [XLEN-1:0]  new_val,
  output logic             writes,
  output logic             illegal
);

  logic [2:0]      op_bits;
  logic            imm_form;
  logic [XLEN-1:0] operand;

  assign op_bits  = op;
  assign imm_form = op_bits[2];
  assign operand  = imm_form ? {{(XLEN-5){1'b0}}, uimm} : src;

  // Set/clear with a zero operand source must not write, so read-only CSRs can be read safely
  always_comb begin
    new_val = old_val;
    writes  = 1'b0;
    case (op_bits[1:0])
      2'b01: begin
        new_val = operand;
        writes  = 1'b1;
      end
      2'b10: begin
        new_val = old_val | operand;
        writes  = imm_form ? (uimm != 5'd0) : !rs1_zero;
      end
      2'b11: begin
        new_val = old_val & ~operand;
        writes  = imm_form ? (uimm != 5'd0) : !rs1_zero;
      end
      default: begin
        new_val = old_val;
        writes  = 1'b0;
      end
    endcase
  end

  assign illegal = writes && (csr_prefix == RO_CSR_PREFIX);

endmodule

// File: rtl/csr_exec_queue.sv
// In-order CSR execution queue: buffers dispatched CSR uops, reads the head CSR
// on an execute grant, and writes the new value back when the head commits.
module csr_exec_queue
  import csr_exec_pkg::*;
#(
  parameter int QDEPTH     = 8,
  parameter int NUM_IN     = 2,
  parameter int NUM_COMMIT = 2
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             flush_in,
  input  logic [NUM_IN-1:0]                in_valid,
  input  logic [NUM_IN-1:0][2:0]           in_op,
  input  logic [NUM_IN-1:0][11:0]          in_csr,
  input  logic [NUM_IN-1:0][XLEN-1:0]      in_src,
  input  logic [NUM_IN-1:0][4:0]           in_uimm,
  input  logic [NUM_IN-1:0]                in_rs1_zero,
  input  logic [NUM_IN-1:0][TAG_W-1:0]     in_tag,
  input  logic [NUM_IN-1:0][RD_W-1:0]      in_rd,
  output logic                             stall_out,
  input  logic                             exec_valid,
  input  logic [TAG_W-1:0]                 exec_tag,
  input  logic [NUM_COMMIT-1:0]            commit_valid,
  input  logic [NUM_COMMIT-1:0][TAG_W-1:0] commit_tag,
  output logic [11:0]                      csr_rd_addr,
  input  logic [XLEN-1:0]                  csr_rd_data,
  output logic                             csr_wr_valid,
  output logic [11:0]                      csr_wr_addr,
  output logic [XLEN-1:0]                  csr_wr_data,
  output logic                             res_valid,
  output logic [TAG_W-1:0]                 res_tag,
  output logic [RD_W-1:0]                  res_rd,
  output logic [XLEN-1:0]                  res_data,
  output logic                             res_illegal
);

  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = $clog2(QDEPTH + 1);

  csrq_entry_t                  q [QDEPTH];
  logic [PTR_W-1:0]             rp;
  logic [PTR_W-1:0]             wp;
  logic [CNT_W-1:0]             count;
  csrq_entry_t                  head;
  logic                         head_valid;
  logic                         exec_fire;
  logic                         commit_hit;
  logic                         pop;
  logic [XLEN-1:0]              new_val;
  logic                         head_writes;
  logic                         head_illegal;
  logic [NUM_IN-1:0]            in_accept;
  logic [NUM_IN-1:0][PTR_W-1:0] alloc_slot;
  logic [CNT_W-1:0]             n_alloc;
  logic [CNT_W-1:0]             count_next;

  assign head       = q[rp];
  assign head_valid = (count != '0);
  assign exec_fire  = head_valid && (head.state == ST_WAIT) && exec_valid && (exec_tag == head.tag);

  always_comb begin
    commit_hit = 1'b0;
    for (int i = 0; i < NUM_COMMIT; i++) begin
      if (commit_valid[i] && (commit_tag[i] == head.tag)) commit_hit = 1'b1;
    end
  end

  // Commit requires DONE at cycle start, so it can never overlap an execute of the same head
  assign pop = head_valid && (head.state == ST_DONE) && commit_hit;

  csr_newval_calc u_newval (
    .op         (head.op),
    .csr_prefix (head.csr[11:10]),
    .old_val    (csr_rd_data),
    .src        (head.src),
    .uimm       (head.uimm),
    .rs1_zero   (head.rs1_zero),
    .new_val    (new_val),
    .writes     (head_writes),
    .illegal    (head_illegal)
  );

  assign csr_rd_addr  = head_valid ? head.csr : 12'd0;
  assign csr_wr_valid = pop && head_writes && !head_illegal;
  assign csr_wr_addr  = pop ? head.csr : 12'd0;
  assign csr_wr_data  = pop ? new_val : '0;

  // Accepted lanes are packed contiguously from wp in lane order
  always_comb begin
    in_accept  = '0;
    alloc_slot = '0;
    n_alloc    = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      in_accept[i]  = in_valid[i] && !stall_out;
      alloc_slot[i] = wp + n_alloc[PTR_W-1:0];
      if (in_accept[i]) n_alloc = n_alloc + CNT_W'(1);
    end
    count_next = count - CNT_W'(pop) + n_alloc;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rp        <= '0;
      wp        <= '0;
      count     <= '0;
      stall_out <= 1'b0;
      for (int i = 0; i < QDEPTH; i++) q[i] <= '0;
    end else if (flush_in) begin
      rp        <= '0;
      wp        <= '0;
      count     <= '0;
      stall_out <= 1'b0;
      for (int i = 0; i < QDEPTH; i++) q[i].state <= ST_FREE;
    end else begin
      if (exec_fire) q[rp].state <= ST_DONE;
      if (pop)       q[rp].state <= ST_FREE;
      for (int i = 0; i < NUM_IN; i++) begin
        if (in_accept[i]) begin
          q[alloc_slot[i]].state    <= ST_WAIT;
          q[alloc_slot[i]].op       <= csr_op_e'(in_op[i]);
          q[alloc_slot[i]].csr      <= in_csr[i];
          q[alloc_slot[i]].src      <= in_src[i];
          q[alloc_slot[i]].uimm     <= in_uimm[i];
          q[alloc_slot[i]].rs1_zero <= in_rs1_zero[i];
          q[alloc_slot[i]].tag      <= in_tag[i];
          q[alloc_slot[i]].rd       <= in_rd[i];
        end
      end
      rp        <= rp + PTR_W'(pop);
      wp        <= wp + n_alloc[PTR_W-1:0];
      count     <= count_next;
      stall_out <= (CNT_W'(QDEPTH) - count_next) < CNT_W'(NUM_IN);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      res_valid   <= 1'b0;
      res_tag     <= '0;
      res_rd      <= '0;
      res_data    <= '0;
      res_illegal <= 1'b0;
    end else if (flush_in || !exec_fire) begin
      res_valid   <= 1'b0;
      res_tag     <= '0;
      res_rd      <= '0;
      res_data    <= '0;
      res_illegal <= 1'b0;
    end else begin
      res_valid   <= 1'b1;
      res_tag     <= head.tag;
      res_rd      <= head.rd;
      res_data    <= csr_rd_data;
      res_illegal <= head_illegal;
    end
  end

  // Dispatch must honour stall_out; a uop offered while stalled is lost
  assert property (@(posedge clock) disable iff (reset) !(stall_out && (|in_valid)));

endmodule
